// File: rtl/counter_interval_ctrl_if.sv
// Control bundle between the sequencing master (firmware/control FSM) and
// counter_interval_ctrl.
interface counter_interval_ctrl_if #(
  parameter int CNT_W = 4,
  parameter int PRE_W = 8
);
  logic             start;
  logic             stop;
  logic             periodic;
  logic [CNT_W-1:0] target;
  logic [PRE_W-1:0] prescale;
  logic             cnt_en;
  logic             cnt_clr;
  logic [CNT_W-1:0] count;
  logic             busy;
  logic             done;
  logic             start_ignored;

  modport master (
    output start, stop, periodic, target, prescale,
    input  cnt_en, cnt_clr, count, busy, done, start_ignored
  );

  modport slave (
    input  start, stop, periodic, target, prescale,
    output cnt_en, cnt_clr, count, busy, done, start_ignored
  );
endinterface

// File: rtl/counter_interval_ctrl.sv
// Sequencing controller for the 4-bit T-flip-flop counter: converts a start
// request into clear/enable strobes, tracks the count and flags completion.
module counter_interval_ctrl #(
  parameter int CNT_W = 4,
  parameter int PRE_W = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  counter_interval_ctrl_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;
  logic [PRE_W-1:0] pre_r;
  logic [PRE_W-1:0] pre_nxt_s;
  logic [CNT_W-1:0] tgt_r;
  logic [PRE_W-1:0] psc_r;
  logic             per_r;
  logic             cnt_clr_r;
  logic             busy_r;
  logic             done_r;
  logic             ign_r;

  logic             tick_s;
  logic             term_s;
  logic             accept_s;
  logic             restart_s;

  // Tick/terminal detection; the tick feeds cnt_en without a register stage.
  always_comb begin
    tick_s    = (state_r == ST_RUN) && (pre_r == psc_r);
    term_s    = tick_s && (count_r == tgt_r);
    accept_s  = (state_r == ST_IDLE) && bus.start && !bus.stop;
    restart_s = term_s && per_r && !bus.stop;
  end

  // Next-state logic; stop always wins over a terminal tick.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ST_ARM;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ARM: begin
        if (bus.stop) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.stop) begin
          state_nxt_s = ST_IDLE;
        end else if (term_s && !per_r) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Count and prescaler updates; both freeze when stop is seen.
  always_comb begin
    count_nxt_s = count_r;
    pre_nxt_s   = pre_r;
    case (state_r)
      ST_ARM: begin
        if (bus.stop) begin
          count_nxt_s = count_r;
          pre_nxt_s   = pre_r;
        end else begin
          count_nxt_s = {CNT_W{1'b0}};
          pre_nxt_s   = {PRE_W{1'b0}};
        end
      end
      ST_RUN: begin
        if (bus.stop) begin
          count_nxt_s = count_r;
          pre_nxt_s   = pre_r;
        end else if (tick_s) begin
          pre_nxt_s = {PRE_W{1'b0}};
          if (!term_s) begin
            count_nxt_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end else if (per_r) begin
            count_nxt_s = {CNT_W{1'b0}};
          end else begin
            count_nxt_s = count_r;
          end
        end else begin
          pre_nxt_s = pre_r + {{(PRE_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        count_nxt_s = count_r;
        pre_nxt_s   = pre_r;
      end
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r   <= ST_IDLE;
      count_r   <= {CNT_W{1'b0}};
      pre_r     <= {PRE_W{1'b0}};
      tgt_r     <= {CNT_W{1'b0}};
      psc_r     <= {PRE_W{1'b0}};
      per_r     <= 1'b0;
      cnt_clr_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      ign_r     <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      count_r   <= count_nxt_s;
      pre_r     <= pre_nxt_s;
      cnt_clr_r <= (state_nxt_s == ST_ARM);
      busy_r    <= (state_nxt_s == ST_ARM) || (state_nxt_s == ST_RUN);
      done_r    <= (state_nxt_s == ST_DONE) || restart_s;
      ign_r     <= bus.start && (state_r != ST_IDLE);
      if (accept_s) begin
        tgt_r <= bus.target;
        psc_r <= bus.prescale;
        per_r <= bus.periodic;
      end else begin
        tgt_r <= tgt_r;
        psc_r <= psc_r;
        per_r <= per_r;
      end
    end
  end

  assign bus.cnt_en        = tick_s;
  assign bus.cnt_clr       = cnt_clr_r;
  assign bus.count         = count_r;
  assign bus.busy          = busy_r;
  assign bus.done          = done_r;
  assign bus.start_ignored = ign_r;

endmodule

// File: tb/tb_counter_interval_ctrl.sv
// Scoreboard bench for counter_interval_ctrl: expected done events are queued
// when a start is driven and matched when the DUT raises done.
module tb_counter_interval_ctrl;

  typedef struct {
    int cyc;
    int cnt;
    int ticks;
    int busy;
  } exp_t;

  logic clk;
  logic resetn;
  int   cyc;
  int   ticks;
  int   checks_cnt;
  int   errors_cnt;
  exp_t exp_q[$];

  counter_interval_ctrl_if #(.CNT_W(4), .PRE_W(8)) bus ();

  counter_interval_ctrl #(.CNT_W(4), .PRE_W(8)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int act, input int exp);
    checks_cnt++;
    if (act != exp) begin
      errors_cnt++;
      $display("FAIL %s act=%0d exp=%0d (cyc %0d)", tag, act, exp, cyc);
    end
  endtask

  // Drive one start; queue n_done expected done events of interval (T+1)(P+1).
  task automatic start_txn(input int t, input int p, input bit per, input int n_done, output int k);
    int n;
    exp_t e;
    @(posedge clk);
    #1;
    bus.start    = 1'b1;
    bus.stop     = 1'b0;
    bus.target   = 4'(t);
    bus.prescale = 8'(p);
    bus.periodic = per;
    k = cyc + 1;
    n = (t + 1) * (p + 1);
    for (int i = 1; i <= n_done; i++) begin
      e.cyc   = k + i * n + 1;
      e.cnt   = per ? 0 : t;
      e.ticks = t + 1;
      e.busy  = per ? 1 : 0;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    check("arm_cnt_clr", int'(bus.cnt_clr), 1);
    check("arm_busy", int'(bus.busy), 1);
  endtask

  task automatic wait_empty(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    check("done_timeout", exp_q.size(), 0);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: match done pulses against the queue and check the count steps.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resetn) begin
        if (bus.cnt_clr) ticks = 0;
        if (bus.done) begin
          if (exp_q.size() == 0) begin
            check("spurious_done", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("done_cyc", cyc, e.cyc);
            check("done_ticks", ticks, e.ticks);
            check("done_count", int'(bus.count), e.cnt);
            check("done_busy", int'(bus.busy), e.busy);
          end
          ticks = 0;
        end
        if (bus.cnt_en) begin
          check("count_step", int'(bus.count), ticks);
          ticks++;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired act=running exp=finished");
    $fatal(1);
  end

  initial begin
    int k;
    cyc = 0;
    ticks = 0;
    checks_cnt = 0;
    errors_cnt = 0;
    resetn = 1'b0;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.periodic = 1'b0;
    bus.target = 4'd0;
    bus.prescale = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_count", int'(bus.count), 0);
    check("rst_cnt_en", int'(bus.cnt_en), 0);
    check("rst_cnt_clr", int'(bus.cnt_clr), 0);
    check("rst_ign", int'(bus.start_ignored), 0);
    @(posedge clk);
    #1;
    resetn = 1'b1;

    // One-shot T=3, P=1: done after edge k+9.
    start_txn(3, 1, 1'b0, 1, k);
    wait_empty(40);
    @(negedge clk);
    check("oneshot_idle_busy", int'(bus.busy), 0);

    // Periodic T=1, P=0: three done pulses two cycles apart, then stop.
    start_txn(1, 0, 1'b1, 3, k);
    wait_empty(40);
    wait_until(k + 7);
    bus.stop = 1'b1;
    @(posedge clk);
    #1;
    bus.stop = 1'b0;
    @(negedge clk);
    check("periodic_stop_busy", int'(bus.busy), 0);
    repeat (6) @(negedge clk);
    check("periodic_stop_done", int'(bus.done), 0);

    // T=0, P=0 one-shot: single tick, done after edge k+2.
    start_txn(0, 0, 1'b0, 1, k);
    wait_empty(20);

    // Stop on the terminal tick (T=2, P=1 -> terminal cycle ends at edge k+7).
    start_txn(2, 1, 1'b0, 0, k);
    wait_until(k + 6);
    bus.stop = 1'b1;
    @(posedge clk);
    #1;
    bus.stop = 1'b0;
    @(negedge clk);
    check("stopterm_busy", int'(bus.busy), 0);
    check("stopterm_count", int'(bus.count), 2);
    repeat (4) @(negedge clk);
    check("stopterm_done", int'(bus.done), 0);

    // Start mid-RUN with different settings is ignored; schedule unchanged.
    start_txn(3, 2, 1'b0, 1, k);
    wait_until(k + 4);
    bus.start    = 1'b1;
    bus.target   = 4'd9;
    bus.prescale = 8'd0;
    bus.periodic = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    check("ign_pulse", int'(bus.start_ignored), 1);
    @(negedge clk);
    check("ign_single", int'(bus.start_ignored), 0);
    wait_empty(40);

    // Reset mid-RUN with a long interval, then a short run afterwards.
    start_txn(15, 255, 1'b0, 0, k);
    repeat (20) @(negedge clk);
    check("long_busy", int'(bus.busy), 1);
    @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    check("arst_busy", int'(bus.busy), 0);
    check("arst_count", int'(bus.count), 0);
    check("arst_cnt_en", int'(bus.cnt_en), 0);
    check("arst_cnt_clr", int'(bus.cnt_clr), 0);
    check("arst_done", int'(bus.done), 0);
    check("arst_ign", int'(bus.start_ignored), 0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    start_txn(2, 0, 1'b0, 1, k);
    wait_empty(20);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/counter_interval_ctrl.md
# counter_interval_ctrl

Sequencing controller for the four-bit T-flip-flop counter. It accepts a start request with a target count and a prescale divisor, and generates the counter's enable and clear strobes. It tracks the count and reports completion with a one-cycle `done` pulse, in one-shot or periodic mode. It sits between the firmware/control FSM and the counter, so the counter never free-runs on the system clock.

## Interface
Parameters:
- CNT_W, 4, width of count/target (matches the counter)
- PRE_W, 8, width of prescale divisor

Ports:
- clk  in  1  system clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- start  in  1  request; sampled each rising edge
- stop  in  1  abort; sampled each rising edge
- periodic  in  1  latched on accepted start: 1 = auto-restart
- target  in  CNT_W  terminal count T, latched on accepted start
- prescale  in  PRE_W  divisor P (tick every P+1 cycles), latched on accepted start
- cnt_en  out  1  counter enable, high for exactly one cycle per tick
- cnt_clr  out  1  counter clear, one-cycle pulse
- count  out  CNT_W  mirror of the current count
- busy  out  1  high in ARM and RUN
- done  out  1  one-cycle completion pulse
- start_ignored  out  1  one-cycle pulse when start arrives while busy

## Operation
- Reset (async, resetn=0):
  - state=IDLE.
  - count, prescaler, latched T/P/periodic all 0.
  - cnt_en, cnt_clr, busy, done, start_ignored all 0.
- States: IDLE, ARM, RUN, DONE (binary encoded; unused codes go to IDLE).
- IDLE:
  - start=1 and stop=0: latch T, P and periodic; go to ARM.
  - Otherwise stay in IDLE; count holds its last value.
- ARM (one cycle):
  - cnt_clr=1, busy=1; count←0, prescaler←0.
  - Next state is RUN, or IDLE if stop=1.
- RUN:
  - busy=1. The prescaler increments each cycle.
  - A tick occurs when prescaler==P: prescaler←0 and cnt_en=1 (combinational, same cycle).
  - Non-terminal tick (count≠T): count←count+1.
  - Terminal tick (count==T), periodic=0: count holds T; go to DONE.
  - Terminal tick (count==T), periodic=1: count←0, prescaler←0, done pulse next cycle; stay in RUN.
- DONE (one cycle): done=1, busy=0; next state IDLE.
- stop in ARM or RUN:
  - Go to IDLE at the next edge; no done pulse; count freezes.
  - stop beats a terminal tick in the same cycle.
- start while in ARM, RUN or DONE is not accepted; start_ignored pulses the next cycle.
- start and stop together in IDLE: stop wins; stay in IDLE; no pulse.
- Arithmetic:
  - Interval length is (T+1)·(P+1) RUN cycles.
  - T=0 gives one tick. P=0 gives a tick every cycle.
  - count never exceeds T, so it does not wrap.
- All outputs except cnt_en are registered.

## Timing
- Start sampled at edge k gives:
  - ARM in cycle k+1 (cnt_clr=1, busy=1).
  - RUN from edge k+1.
  - First cnt_en in the (P+1)-th RUN cycle.
- Terminal tick occurs in the cycle ending at edge k+(T+1)(P+1)+1; done is high in the cycle after that edge.
- Periodic: successive done pulses are exactly (T+1)(P+1) cycles apart. cnt_clr is not reasserted on auto-restart; count is reset internally.
- After a one-shot: the earliest new start is accepted at the edge where the state is IDLE, i.e. one cycle after done.
- Reset mid-operation: all outputs return to 0 immediately; any pending done pulse is lost.

## Test plan
- Reset, then start with T=3, P=1, periodic=0 at edge k:
  - cnt_clr high in cycle k+1.
  - cnt_en high every 2nd RUN cycle, 4 pulses total.
  - count steps 0,1,2,3.
  - done is a single pulse after edge k+9; busy falls with done.
- Periodic with T=1, P=0:
  - cnt_en is high every RUN cycle.
  - done pulses every 2 cycles.
  - count toggles 0,1,0,1.
  - stop at an arbitrary edge: IDLE next cycle, no further done.
- T=0, P=0 one-shot: one cnt_en; done after edge k+2.
- stop asserted in the same cycle as the terminal tick: no done; state IDLE; count=T.
- start pulsed mid-RUN: start_ignored high for one cycle; latched T/P unchanged; the interval completes on schedule.
- resetn dropped in the middle of RUN with T=15, P=255:
  - All outputs go to 0 asynchronously.
  - After release, a start with new T=2, P=0 completes in 3 RUN cycles.
